// File: rtl/apb_pkg.sv
// Shared definitions for the APB register responder: FSM states, address width,
// default identification value, the read-only ID register index and the error rule.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;
  localparam logic [APB_ADDR_W-1:0] REG_ID = 5'd0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Unmapped indices and writes to the ID register are refused.
  function automatic logic apb_is_err(input logic [APB_ADDR_W-1:0] addr,
                                      input logic wr,
                                      input logic [APB_ADDR_W:0] num_regs);
    logic err;
    err = 1'b0;
    if ({1'b0, addr} >= num_regs) begin
      err = 1'b1;
    end else if (wr && (addr == REG_ID)) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states; cnt_zero flags that the access may complete.
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       cnt_zero
);

  logic [3:0] cnt_r;

  // Load on setup, count down while the access phase is stalled.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign cnt_zero = (cnt_r == 4'd0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB responder with a bank of DATA_W-bit registers, programmable wait states and
// error response. PSLVERR is driven only when APB_REG_SLAVE_PSLVERR_EN is defined.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                       SYSCLK,
  input  logic                       RST,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [APB_ADDR_W-1:0]      PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] REG_OUT
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [APB_ADDR_W:0] NUM_REGS_W = 6'(NUM_REGS);

  apb_state_e                  state_r;
  logic [APB_ADDR_W-1:0]       addr_r;
  logic                        write_r;
  logic [DATA_W-1:0]           wdata_r;
  logic [DATA_W-1:0]           regs_r [NUM_REGS-1:1];
  logic                        setup_s;
  logic                        access_s;
  logic                        cnt_zero_s;
  logic                        ready_s;
  logic                        err_s;
  logic [DATA_W-1:0]           rdata_s;

  assign setup_s  = (state_r == ST_IDLE) && PSEL && !PENABLE;
  assign access_s = (state_r == ST_ACCESS) && PSEL && PENABLE;
  assign ready_s  = access_s && cnt_zero_s;
  assign err_s    = apb_is_err(addr_r, write_r, NUM_REGS_W);

  apb_wait_ctr u_wait_ctr (
    .SYSCLK   (SYSCLK),
    .RST      (RST),
    .load     (setup_s),
    .load_val (WAIT_LOAD),
    .dec      (access_s),
    .cnt_zero (cnt_zero_s)
  );

  // FSM and setup-phase capture of address, direction and write data.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (setup_s) begin
            state_r <= ST_ACCESS;
            addr_r  <= PADDR;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
          end
        end
        ST_ACCESS: begin
          if (!PSEL || ready_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register bank: commit only on the completing edge of a legal write.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (ready_s && write_r && !err_s) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_r == 5'(i)) begin
          regs_r[i] <= wdata_r;
        end
      end
    end
  end

  // Read mux; register 0 is the constant ID.
  always_comb begin
    rdata_s = '0;
    if (addr_r == REG_ID) begin
      rdata_s = ID_VALUE;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_r == 5'(i)) begin
          rdata_s = regs_r[i];
        end
      end
    end
  end

  always_comb begin
    REG_OUT = '0;
    REG_OUT[0 +: DATA_W] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      REG_OUT[i*DATA_W +: DATA_W] = regs_r[i];
    end
  end

  assign PREADY = ready_s;
  assign PRDATA = (ready_s && !write_r && !err_s) ? rdata_s : '0;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  assign PSLVERR = ready_s && err_s;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: three instances (0, 3 and 2 wait states) share
// the APB bus, with PSEL routed to the instance chosen by sel.
module tb_apb_reg_slave;
  localparam int NR = 16;
  localparam int DW = 32;
  localparam logic [31:0] IDV = 32'hA9B0_0001;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic SYSCLK = 1'b0;
  logic RST, psel, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [31:0] PWDATA;
  int sel;
  logic [2:0] psel_a;
  logic [31:0] prdata_a [3];
  logic pready_a [3];
  logic pslverr_a [3];
  logic [NR*DW-1:0] regout_a [3];
  logic [31:0] prdata_s;
  logic pready_s, pslverr_s;
  logic [NR*DW-1:0] regout_s;
  int n_checks = 0;
  int n_pass = 0;

  always #5 SYSCLK = ~SYSCLK;

  always_comb begin
    psel_a = 3'b000;
    psel_a[sel] = psel;
    prdata_s = prdata_a[sel];
    pready_s = pready_a[sel];
    pslverr_s = pslverr_a[sel];
    regout_s = regout_a[sel];
  end

  apb_reg_slave #(.NUM_REGS(NR), .DATA_W(DW), .WAIT_CYCLES(0)) u_w0 (
    .SYSCLK(SYSCLK), .RST(RST), .PSEL(psel_a[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a[0]), .PREADY(pready_a[0]),
    .PSLVERR(pslverr_a[0]), .REG_OUT(regout_a[0]));
  apb_reg_slave #(.NUM_REGS(NR), .DATA_W(DW), .WAIT_CYCLES(3)) u_w3 (
    .SYSCLK(SYSCLK), .RST(RST), .PSEL(psel_a[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a[1]), .PREADY(pready_a[1]),
    .PSLVERR(pslverr_a[1]), .REG_OUT(regout_a[1]));
  apb_reg_slave #(.NUM_REGS(NR), .DATA_W(DW), .WAIT_CYCLES(2)) u_w2 (
    .SYSCLK(SYSCLK), .RST(RST), .PSEL(psel_a[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a[2]), .PREADY(pready_a[2]),
    .PSLVERR(pslverr_a[2]), .REG_OUT(regout_a[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          ew;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  // One full transfer; bus address/data/direction are scrambled during ACCESS.
  task automatic xfer(input int d, input logic w, input logic [4:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits,
                      output logic to);
    sel = d; psel = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
    tick();
    PENABLE = 1'b1; PADDR = ~a; PWDATA = ~wd; PWRITE = ~w;
    waits = 0; to = 1'b1; rd = '0; err = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge SYSCLK);
      if (pready_s) begin
        rd = prdata_s; err = pslverr_s; to = 1'b0;
        tick();
        break;
      end
      waits++;
      tick();
    end
    psel = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic err, to;
    int waits;

    vt[0]  = '{0, 1'b0, 5'd0,  32'h0,         IDV,           1'b0, 0};
    vt[1]  = '{0, 1'b0, 5'd3,  32'h0,         32'h0,         1'b0, 0};
    vt[2]  = '{0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vt[3]  = '{0, 1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vt[4]  = '{0, 1'b1, 5'd0,  32'h1,         32'h0,         PE,   0};
    vt[5]  = '{0, 1'b1, 5'd20, 32'h1,         32'h0,         PE,   0};
    vt[6]  = '{0, 1'b0, 5'd0,  32'h0,         IDV,           1'b0, 0};
    vt[7]  = '{0, 1'b0, 5'd20, 32'h0,         32'h0,         PE,   0};
    vt[8]  = '{0, 1'b1, 5'd15, 32'h1234_5678, 32'h0,         1'b0, 0};
    vt[9]  = '{0, 1'b0, 5'd15, 32'h0,         32'h1234_5678, 1'b0, 0};
    vt[10] = '{1, 1'b1, 5'd2,  32'hCAFE_0002, 32'h0,         1'b0, 3};
    vt[11] = '{1, 1'b0, 5'd2,  32'h0,         32'hCAFE_0002, 1'b0, 3};

    sel = 0; psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    @(negedge SYSCLK);
    chk("reset_pready", {31'd0, pready_s}, 32'd0);
    chk("reset_prdata", prdata_s, 32'd0);
    chk("reset_pslverr", {31'd0, pslverr_s}, 32'd0);
    chk("reset_reg1", regout_s[1*DW +: DW], 32'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, rd, err, waits, to);
      chk($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("vec%0d_prdata", i), rd, vt[i].erd);
      chk($sformatf("vec%0d_pslverr", i), {31'd0, err}, {31'd0, vt[i].eerr});
      chk($sformatf("vec%0d_waits", i), waits, vt[i].ew);
    end

    sel = 0;
    @(negedge SYSCLK);
    chk("regout_reg5", regout_s[5*DW +: DW], 32'hDEAD_BEEF);
    chk("regout_reg0", regout_s[0 +: DW], IDV);
    chk("regout_reg15", regout_s[15*DW +: DW], 32'h1234_5678);
    tick();

    // WAIT_CYCLES=3: PREADY only on the 4th ACCESS cycle, register updates on that edge.
    sel = 1; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd9; PWDATA = 32'h0000_0099;
    tick();
    PENABLE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge SYSCLK);
      chk($sformatf("w3_pready_c%0d", k), {31'd0, pready_s}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("w3_reg9_pre_c%0d", k), regout_s[9*DW +: DW], 32'd0);
      tick();
    end
    psel = 1'b0; PENABLE = 1'b0;
    @(negedge SYSCLK);
    chk("w3_reg9_post", regout_s[9*DW +: DW], 32'h0000_0099);
    tick();

    // Abort on WAIT_CYCLES=2: drop PSEL mid-ACCESS on a write to reg 7.
    sel = 2; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd7; PWDATA = 32'h7777_7777;
    tick();
    PENABLE = 1'b1;
    tick();
    psel = 1'b0; PENABLE = 1'b0;
    tick();
    @(negedge SYSCLK);
    chk("abort_reg7", regout_s[7*DW +: DW], 32'd0);
    chk("abort_pready", {31'd0, pready_s}, 32'd0);
    tick();
    xfer(2, 1'b1, 5'd7, 32'h0000_0707, rd, err, waits, to);
    chk("post_abort_wr_waits", waits, 2);
    chk("post_abort_wr_err", {31'd0, err}, 32'd0);
    xfer(2, 1'b0, 5'd7, 32'h0, rd, err, waits, to);
    chk("post_abort_rd_data", rd, 32'h0000_0707);
    chk("post_abort_rd_waits", waits, 2);

    // PENABLE without a setup phase is ignored.
    sel = 0; psel = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 5'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge SYSCLK);
      chk($sformatf("nosetup_pready_c%0d", k), {31'd0, pready_s}, 32'd0);
      tick();
    end
    psel = 1'b0; PENABLE = 1'b0;
    tick();

    // Reset during the ACCESS phase of a write to reg 4.
    sel = 0; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd4; PWDATA = 32'h4444_4444;
    tick();
    PENABLE = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge SYSCLK);
    chk("rst_mid_pready", {31'd0, pready_s}, 32'd0);
    chk("rst_mid_reg4", regout_s[4*DW +: DW], 32'd0);
    chk("rst_mid_reg5", regout_s[5*DW +: DW], 32'd0);
    tick();
    psel = 1'b0; PENABLE = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
